phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 148 ++++++++++++++
 tb/tb_phase_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with a debounced exec button, run/step/stop, HLT and IN suspension.
// Latency: press pulse 2 sync + DEBOUNCE_CYCLES cycles after exec settles high; all outputs registered.
module phase_sequencer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        step_mode,
    input  logic        is_hlt,
    input  logic        is_in,
    output logic [4:0]  phase,
    output logic        running,
    output logic        system_stopped,
    output logic        in_wait,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    localparam logic [4:0] P1 = 5'b00001;
    localparam logic [4:0] P2 = 5'b00010;
    localparam logic [4:0] P3 = 5'b00100;
    localparam logic [4:0] P4 = 5'b01000;
    localparam logic [4:0] P5 = 5'b10000;

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_RUN,
        ST_STEP,
        ST_IN_WAIT,
        ST_HALTED
    } state_t;

    state_t          state, state_nxt;
    logic [4:0]      phase_nxt;
    logic            stop_req, stop_nxt;
    logic            origin_step, origin_nxt;
    logic [15:0]     count_nxt;

    logic            sync1, sync2;
    logic [CW-1:0]   db_cnt;
    logic            armed;
    logic            press;

    // armed records that a 0 has been seen since the last pulse, so one press yields one pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            armed  <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync1 <= exec;
            sync2 <= sync1;
            press <= 1'b0;
            if (!sync2) begin
                db_cnt <= '0;
                armed  <= 1'b1;
            end else if (armed) begin
                if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    press  <= 1'b1;
                    armed  <= 1'b0;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        stop_nxt   = stop_req;
        origin_nxt = origin_step;
        count_nxt  = instr_count;
        case (state)
            ST_STOPPED, ST_HALTED: begin
                if (press) begin
                    state_nxt = step_mode ? ST_STEP : ST_RUN;
                    phase_nxt = P1;
                    stop_nxt  = 1'b0;
                end
            end
            ST_RUN, ST_STEP: begin
                if (state == ST_RUN && press)
                    stop_nxt = 1'b1;
                phase_nxt = {phase[3:0], phase[4]};
                if (phase == P2 && is_hlt) begin
                    state_nxt = ST_HALTED;
                    phase_nxt = '0;
                    stop_nxt  = 1'b0;
                end else if (phase == P3 && is_in) begin
                    state_nxt  = ST_IN_WAIT;
                    phase_nxt  = '0;
                    origin_nxt = (state == ST_STEP);
                end else if (phase == P5) begin
                    count_nxt = instr_count + 16'd1;
                    // a press landing on p5 already shows in stop_nxt, so it stops at this boundary
                    if (state == ST_STEP || stop_nxt) begin
                        state_nxt = ST_STOPPED;
                        phase_nxt = '0;
                        stop_nxt  = 1'b0;
                    end
                end
            end
            ST_IN_WAIT: begin
                if (press) begin
                    state_nxt = origin_step ? ST_STEP : ST_RUN;
                    phase_nxt = P4;
                end
            end
            default: begin
                state_nxt = ST_STOPPED;
                phase_nxt = '0;
                stop_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_STOPPED;
            phase          <= '0;
            stop_req       <= 1'b0;
            origin_step    <= 1'b0;
            instr_count    <= '0;
            running        <= 1'b0;
            system_stopped <= 1'b1;
            in_wait        <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_nxt;
            phase          <= phase_nxt;
            stop_req       <= stop_nxt;
            origin_step    <= origin_nxt;
            instr_count    <= count_nxt;
            running        <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
            system_stopped <= !((state_nxt == ST_RUN) || (state_nxt == ST_STEP));
            in_wait        <= (state_nxt == ST_IN_WAIT);
            halted         <= (state_nxt == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: debounce, run/stop, step, HLT, IN, counter wrap, async reset.
module tb_phase_sequencer;

    logic        clock;
    logic        reset;
    logic        exec;
    logic        step_mode;
    logic        is_hlt;
    logic        is_in;
    logic [4:0]  phase;
    logic        running;
    logic        system_stopped;
    logic        in_wait;
    logic        halted;
    logic [15:0] instr_count;

    int n_vec = 0;
    int n_err = 0;
    int cexp  = 0;

    phase_sequencer #(.DEBOUNCE_CYCLES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .exec           (exec),
        .step_mode      (step_mode),
        .is_hlt         (is_hlt),
        .is_in          (is_in),
        .phase          (phase),
        .running        (running),
        .system_stopped (system_stopped),
        .in_wait        (in_wait),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        exec   = 1'b0;
        is_hlt = 1'b0;
        is_in  = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; exec = 1'b0; step_mode = 1'b0; is_hlt = 1'b0; is_in = 1'b0;
        tick();
        n_vec++;
        if ({phase, running, system_stopped, in_wait, halted, instr_count} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_state got ph=%0d run=%0b stp=%0b iw=%0b h=%0b cnt=%0d want ph=0 run=0 stp=1 iw=0 h=0 cnt=0",
                     phase, running, system_stopped, in_wait, halted, instr_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_chatter_run();
        int idx;
        step_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            exec = ((i / 3) % 2 == 0);
            tick();
        end
        n_vec++;
        if (running !== 1'b0) begin n_err++; $display("FAIL chatter_ignored running=%0b want 0", running); end
        exec = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (phase !== 5'd0) begin n_err++; $display("FAIL debounce_early phase=%0d want 0", phase); end
        tick();
        n_vec++;
        if ({phase, running, system_stopped} !== {5'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL run_start ph=%0d run=%0b stp=%0b want ph=1 run=1 stp=0", phase, running, system_stopped);
        end
        tick();
        exec = 1'b0;
        idx = 1;
        cexp = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            idx = (idx + 1) % 5;
            if (idx == 0) cexp++;
            n_vec++;
            if (phase !== 5'(1 << idx) || instr_count !== 16'(cexp)) begin
                n_err++;
                $display("FAIL run_seq[%0d] ph=%0d cnt=%0d want ph=%0d cnt=%0d", k, phase, instr_count, 1 << idx, cexp);
            end
        end
    endtask

    task automatic test_stop_mid();
        n_vec++;
        if (phase !== 5'd2) begin n_err++; $display("FAIL stop_pre phase=%0d want 2", phase); end
        exec = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (phase !== 5'd2 || instr_count !== 16'(cexp + 2)) begin
            n_err++;
            $display("FAIL stop_press_p2 ph=%0d cnt=%0d want ph=2 cnt=%0d", phase, instr_count, cexp + 2);
        end
        cexp += 2;
        tick(); tick(); tick();
        exec = 1'b0;
        n_vec++;
        if (phase !== 5'd16 || running !== 1'b1) begin
            n_err++;
            $display("FAIL stop_finish ph=%0d run=%0b want ph=16 run=1", phase, running);
        end
        tick();
        cexp++;
        n_vec++;
        if ({phase, running, system_stopped} !== {5'd0, 1'b0, 1'b1} || instr_count !== 16'(cexp)) begin
            n_err++;
            $display("FAIL stopped ph=%0d run=%0b stp=%0b cnt=%0d want ph=0 run=0 stp=1 cnt=%0d",
                     phase, running, system_stopped, instr_count, cexp);
        end
        repeat (15) tick();
        n_vec++;
        if (running !== 1'b0 || phase !== 5'd0) begin
            n_err++;
            $display("FAIL stay_stopped run=%0b ph=%0d want run=0 ph=0", running, phase);
        end
    endtask

    task automatic test_press_at_p5();
        exec = 1'b1;
        repeat (11) tick();
        n_vec++;
        if (phase !== 5'd1) begin n_err++; $display("FAIL p5_start phase=%0d want 1", phase); end
        tick();
        exec = 1'b0;
        repeat (3) tick();
        exec = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (phase !== 5'd16 || instr_count !== 16'(cexp + 2)) begin
            n_err++;
            $display("FAIL p5_press ph=%0d cnt=%0d want ph=16 cnt=%0d", phase, instr_count, cexp + 2);
        end
        tick();
        cexp += 3;
        n_vec++;
        if ({phase, running} !== {5'd0, 1'b0} || instr_count !== 16'(cexp)) begin
            n_err++;
            $display("FAIL p5_stop ph=%0d run=%0b cnt=%0d want ph=0 run=0 cnt=%0d", phase, running, instr_count, cexp);
        end
        tick();
        exec = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exec = 1'b1;
            repeat (11) tick();
            n_vec++;
            if (phase !== 5'd1 || running !== 1'b1) begin
                n_err++;
                $display("FAIL step_start[%0d] ph=%0d run=%0b want ph=1 run=1", i, phase, running);
            end
            tick();
            exec = 1'b0;
            repeat (4) tick();
            n_vec++;
            if ({phase, system_stopped} !== {5'd0, 1'b1} || instr_count !== 16'(i + 1)) begin
                n_err++;
                $display("FAIL step_done[%0d] ph=%0d stp=%0b cnt=%0d want ph=0 stp=1 cnt=%0d",
                         i, phase, system_stopped, instr_count, i + 1);
            end
            repeat (4) tick();
        end
        n_vec++;
        if (instr_count !== 16'd3 || system_stopped !== 1'b1) begin
            n_err++;
            $display("FAIL step_total cnt=%0d stp=%0b want cnt=3 stp=1", instr_count, system_stopped);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        step_mode = 1'b0;
        exec = 1'b1;
        repeat (11) tick();
        is_hlt = 1'b1;
        is_in  = 1'b1;
        tick();
        exec = 1'b0;
        tick();
        n_vec++;
        if ({halted, phase, in_wait, running, system_stopped} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1} || instr_count !== 16'd0) begin
            n_err++;
            $display("FAIL halt_enter h=%0b ph=%0d iw=%0b run=%0b stp=%0b cnt=%0d want h=1 ph=0 iw=0 run=0 stp=1 cnt=0",
                     halted, phase, in_wait, running, system_stopped, instr_count);
        end
        repeat (8) tick();
        n_vec++;
        if (halted !== 1'b1 || in_wait !== 1'b0) begin
            n_err++;
            $display("FAIL halt_hold h=%0b iw=%0b want h=1 iw=0", halted, in_wait);
        end
        is_hlt = 1'b0;
        is_in  = 1'b0;
        exec = 1'b1;
        repeat (11) tick();
        n_vec++;
        if ({phase, running, halted} !== {5'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL halt_resume ph=%0d run=%0b h=%0b want ph=1 run=1 h=0", phase, running, halted);
        end
        tick();
        exec = 1'b0;
    endtask

    task automatic test_in_wait();
        tick();
        n_vec++;
        if (phase !== 5'd4) begin n_err++; $display("FAIL in_pre phase=%0d want 4", phase); end
        is_in = 1'b1;
        tick();
        n_vec++;
        if ({in_wait, phase, running} !== {1'b1, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL in_enter iw=%0b ph=%0d run=%0b want iw=1 ph=0 run=0", in_wait, phase, running);
        end
        repeat (20) tick();
        is_in = 1'b0;
        exec = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (in_wait !== 1'b1 || phase !== 5'd0) begin
            n_err++;
            $display("FAIL in_hold iw=%0b ph=%0d want iw=1 ph=0", in_wait, phase);
        end
        tick();
        n_vec++;
        if ({phase, running, in_wait} !== {5'd8, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL in_resume ph=%0d run=%0b iw=%0b want ph=8 run=1 iw=0", phase, running, in_wait);
        end
        tick();
        exec = 1'b0;
        n_vec++;
        if (phase !== 5'd16) begin n_err++; $display("FAIL in_p5 phase=%0d want 16", phase); end
        tick();
        n_vec++;
        if (phase !== 5'd1 || instr_count !== 16'd1 || running !== 1'b1) begin
            n_err++;
            $display("FAIL in_retire ph=%0d cnt=%0d run=%0b want ph=1 cnt=1 run=1", phase, instr_count, running);
        end
        tick();
    endtask

    task automatic test_wrap_reset();
        force dut.instr_count = 16'hFFFF;
        tick();
        release dut.instr_count;
        tick();
        tick();
        n_vec++;
        if (phase !== 5'd16 || instr_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_pre ph=%0d cnt=%0h want ph=16 cnt=ffff", phase, instr_count);
        end
        tick();
        n_vec++;
        if (phase !== 5'd1 || instr_count !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap ph=%0d cnt=%0h want ph=1 cnt=0", phase, instr_count);
        end
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({phase, running, system_stopped, in_wait, halted, instr_count} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL async_reset ph=%0d run=%0b stp=%0b iw=%0b h=%0b cnt=%0d want ph=0 run=0 stp=1 iw=0 h=0 cnt=0",
                     phase, running, system_stopped, in_wait, halted, instr_count);
        end
        exec = 1'b1;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        exec = 1'b0;
        repeat (10) tick();
        n_vec++;
        if (running !== 1'b0 || phase !== 5'd0 || instr_count !== 16'd0) begin
            n_err++;
            $display("FAIL post_reset_idle run=%0b ph=%0d cnt=%0d want run=0 ph=0 cnt=0", running, phase, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_chatter_run();
        test_stop_mid();
        test_press_at_p5();
        test_step();
        test_halt();
        test_in_wait();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
